// File: rtl/neander_control_unit.sv
// rtl/neander_control_unit.sv - Moore control FSM for the Neander accumulator CPU
module neander_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       n_flag,
    input  logic       z_flag,
    output logic       sel_pc,
    output logic       sel_ac,
    output logic       load_rem,
    output logic       load_rdm,
    output logic       load_ri,
    output logic       load_pc,
    output logic       load_ac,
    output logic       load_nz,
    output logic       inc_pc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [4:0] {
        S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_NOP, S_A0, S_A1, S_A2, S_A3,
        S_S0, S_S1, S_O0, S_O1, S_O2,
        S_NOT, S_J3, S_SKIP, S_HLT, S_HALT
    } state_t;

    // Instruction class latched at DEC so the shared A0..A3 states know where to go next.
    typedef enum logic [2:0] {
        K_STA, K_LDA, K_ADD, K_OR, K_AND, K_JMP
    } kind_t;

    state_t state, state_next;
    kind_t  kind, kind_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_F0;
            kind  <= K_JMP;
        end else begin
            state <= state_next;
            kind  <= kind_next;
        end
    end

    always_comb begin
        state_next = state;
        kind_next  = kind;
        sel_pc     = 1'b0;
        sel_ac     = 1'b0;
        load_rem   = 1'b0;
        load_rdm   = 1'b0;
        load_ri    = 1'b0;
        load_pc    = 1'b0;
        load_ac    = 1'b0;
        load_nz    = 1'b0;
        inc_pc     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state)
            S_F0: begin
                sel_pc     = 1'b1;
                load_rem   = 1'b1;
                state_next = S_F1;
            end
            S_F1: begin
                mem_rd     = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_F2;
            end
            S_F2: begin
                load_rdm   = 1'b1;
                state_next = S_F3;
            end
            S_F3: begin
                load_ri    = 1'b1;
                state_next = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    4'b0001: begin state_next = S_A0; kind_next = K_STA; end
                    4'b0010: begin state_next = S_A0; kind_next = K_LDA; end
                    4'b0011: begin state_next = S_A0; kind_next = K_ADD; end
                    4'b0100: begin state_next = S_A0; kind_next = K_OR;  end
                    4'b0101: begin state_next = S_A0; kind_next = K_AND; end
                    4'b0110: state_next = S_NOT;
                    4'b1000: begin state_next = S_A0; kind_next = K_JMP; end
                    4'b1001: begin
                        state_next = n_flag ? S_A0 : S_SKIP;
                        kind_next  = K_JMP;
                    end
                    4'b1010: begin
                        state_next = z_flag ? S_A0 : S_SKIP;
                        kind_next  = K_JMP;
                    end
                    4'b1111: state_next = S_HLT;
                    default: state_next = S_NOP;
                endcase
            end
            S_NOP: begin
                instr_done = 1'b1;
                state_next = S_F0;
            end
            S_A0: begin
                sel_pc     = 1'b1;
                load_rem   = 1'b1;
                state_next = S_A1;
            end
            S_A1: begin
                mem_rd     = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_A2;
            end
            S_A2: begin
                load_rdm   = 1'b1;
                state_next = (kind == K_JMP) ? S_J3 : S_A3;
            end
            S_A3: begin
                load_rem   = 1'b1;
                state_next = (kind == K_STA) ? S_S0 : S_O0;
            end
            S_S0: begin
                sel_ac     = 1'b1;
                load_rdm   = 1'b1;
                state_next = S_S1;
            end
            S_S1: begin
                mem_wr     = 1'b1;
                instr_done = 1'b1;
                state_next = S_F0;
            end
            S_O0: begin
                mem_rd     = 1'b1;
                state_next = S_O1;
            end
            S_O1: begin
                load_rdm   = 1'b1;
                state_next = S_O2;
            end
            S_O2: begin
                load_ac    = 1'b1;
                load_nz    = 1'b1;
                instr_done = 1'b1;
                case (kind)
                    K_ADD:   alu_op = 3'b001;
                    K_OR:    alu_op = 3'b010;
                    K_AND:   alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
                state_next = S_F0;
            end
            S_NOT: begin
                load_ac    = 1'b1;
                load_nz    = 1'b1;
                alu_op     = 3'b100;
                instr_done = 1'b1;
                state_next = S_F0;
            end
            S_J3: begin
                load_pc    = 1'b1;
                instr_done = 1'b1;
                state_next = S_F0;
            end
            S_SKIP: begin
                inc_pc     = 1'b1;
                instr_done = 1'b1;
                state_next = S_F0;
            end
            S_HLT: begin
                halted     = 1'b1;
                instr_done = 1'b1;
                state_next = S_HALT;
            end
            S_HALT: begin
                halted     = 1'b1;
            end
            default: state_next = S_F0;
        endcase
    end

endmodule

// File: tb/tb_neander_control_unit.sv
// tb/tb_neander_control_unit.sv - randomized model-checked bench for neander_control_unit
module tb_neander_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       n_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       sel_pc, sel_ac, load_rem, load_rdm, load_ri, load_pc, load_ac, load_nz;
    logic       inc_pc, mem_rd, mem_wr, instr_done, halted;
    logic [2:0] alu_op;

    neander_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .n_flag(n_flag), .z_flag(z_flag),
        .sel_pc(sel_pc), .sel_ac(sel_ac), .load_rem(load_rem), .load_rdm(load_rdm),
        .load_ri(load_ri), .load_pc(load_pc), .load_ac(load_ac), .load_nz(load_nz),
        .inc_pc(inc_pc), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op),
        .instr_done(instr_done), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam int SEL_PC = 15, SEL_AC = 14, LREM = 13, LRDM = 12, LRI = 11, LPC = 10;
    localparam int LAC = 9, LNZ = 8, INC = 7, MRD = 6, MWR = 5, ALU = 2, DONE = 1, HLT = 0;

    logic [15:0] act;
    assign act = {sel_pc, sel_ac, load_rem, load_rdm, load_ri, load_pc, load_ac, load_nz,
                  inc_pc, mem_rd, mem_wr, alu_op, instr_done, halted};

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int done_cyc = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] b(int i);
        return 16'(1) << i;
    endfunction

    task automatic chk(string name, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, a, e, $time);
        end
    endtask

    // One expected output vector per cycle, checked away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            logic [15:0] e;
            cyc_cnt++;
            if (instr_done && done_cyc == 0) done_cyc = cyc_cnt;
            checks++;
            if ((load_pc && inc_pc) || (mem_rd && mem_wr)) begin
                failures++;
                $display("FAIL exclusive actual=%04h expected=no_conflict at %0t", act, $time);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL cycle%0d actual=%04h expected=%04h at %0t", cyc_cnt, act, e, $time);
                end
            end
        end
    end

    // Reference: instruction -> list of per-cycle output vectors.
    task automatic build(input logic [3:0] op, input logic n, input logic z, input int hold);
        logic [15:0] addr_fetch[3];
        addr_fetch[0] = b(SEL_PC) | b(LREM);
        addr_fetch[1] = b(MRD) | b(INC);
        addr_fetch[2] = b(LRDM);
        foreach (addr_fetch[i]) exp_q.push_back(addr_fetch[i]);
        exp_q.push_back(b(LRI));
        exp_q.push_back(16'd0);
        if (op == 4'd1 || (op >= 4'd2 && op <= 4'd5)) begin
            foreach (addr_fetch[i]) exp_q.push_back(addr_fetch[i]);
            exp_q.push_back(b(LREM));
            if (op == 4'd1) begin
                exp_q.push_back(b(SEL_AC) | b(LRDM));
                exp_q.push_back(b(MWR) | b(DONE));
            end else begin
                exp_q.push_back(b(MRD));
                exp_q.push_back(b(LRDM));
                exp_q.push_back(b(LAC) | b(LNZ) | b(DONE) | (16'(op - 4'd2) << ALU));
            end
        end else if (op == 4'd6) begin
            exp_q.push_back(b(LAC) | b(LNZ) | b(DONE) | (16'(4) << ALU));
        end else if (op == 4'd8 || (op == 4'd9 && n) || (op == 4'd10 && z)) begin
            foreach (addr_fetch[i]) exp_q.push_back(addr_fetch[i]);
            exp_q.push_back(b(LPC) | b(DONE));
        end else if (op == 4'd9 || op == 4'd10) begin
            exp_q.push_back(b(INC) | b(DONE));
        end else if (op == 4'd15) begin
            exp_q.push_back(b(HLT) | b(DONE));
            repeat (hold) exp_q.push_back(b(HLT));
        end else begin
            exp_q.push_back(b(DONE));
        end
    endtask

    // Called in cycle 1 (F0). Opcode is garbage until DEC; flags invert after DEC.
    task automatic run_instr(input logic [3:0] op, input logic n, input logic z,
                             input int hold, input int stop_after);
        int len;
        exp_q.delete();
        build(op, n, z, hold);
        len = exp_q.size();
        if (stop_after > 0) len = stop_after;
        cyc_cnt = 0;
        done_cyc = 0;
        opcode = 4'($urandom);
        n_flag = 1'($urandom);
        z_flag = 1'($urandom);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) begin
                opcode = op;
                n_flag = n;
                z_flag = z;
            end else if (k >= 5) begin
                n_flag = ~n;
                z_flag = ~z;
            end
        end
        if (stop_after == 0) chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("reset_state", act, b(SEL_PC) | b(LREM));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        do_reset();

        run_instr(4'd2, 1'b0, 1'b0, 0, 0);
        chk("lda_done_cycle", done_cyc, 12);
        chk("after_lda_f0", act, b(SEL_PC) | b(LREM));
        run_instr(4'd9, 1'b0, 1'b1, 0, 0);
        chk("jn_skip_done_cycle", done_cyc, 6);
        run_instr(4'd10, 1'b0, 1'b1, 0, 0);
        chk("jz_taken_done_cycle", done_cyc, 9);
        run_instr(4'd1, 1'b1, 1'b1, 0, 0);
        chk("sta_done_cycle", done_cyc, 11);
        run_instr(4'd6, 1'b0, 1'b0, 0, 0);
        chk("not_done_cycle", done_cyc, 6);

        run_instr(4'd3, 1'b0, 1'b0, 0, 10);
        do_reset();
        chk("abort_no_done", done_cyc, 0);
        run_instr(4'd7, 1'b1, 1'b0, 0, 0);
        chk("undef_nop_done_cycle", done_cyc, 6);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, 1'($urandom), 1'($urandom), 0, 0);
        end

        run_instr(4'd15, 1'b0, 1'b0, 22, 0);
        chk("hlt_done_cycle", done_cyc, 6);
        chk("still_halted", act, b(HLT));
        do_reset();
        chk("released_not_halted", 32'(halted), 0);
        run_instr(4'd0, 1'b0, 1'b0, 0, 0);
        chk("nop_done_cycle", done_cyc, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
